// File: rtl/eight_to_three_bit_enc_pkg.sv
// Shared constants and types for the 8-to-3 priority encoder.
package enc_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = $clog2(ENC_IN_W);

  typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage : enc_pkg

// File: rtl/eight_to_three_bit_enc_if.sv
// Bus between a one-hot/request source and the encoder.
// The onehot_err signal exists only when ONEHOT_CHECK_EN is defined.
interface eight_to_three_bit_enc_if;
  import enc_pkg::*;

  logic [ENC_IN_W-1:0] A;
  enc_idx_t            y;
  logic                v;
`ifdef ONEHOT_CHECK_EN
  logic                onehot_err;
`endif

  // Source side: drives the request vector, observes the encoded result.
  modport master (
    output A,
    input  y,
    input  v
`ifdef ONEHOT_CHECK_EN
    ,
    input  onehot_err
`endif
  );

  // Encoder side: samples the request vector, drives the encoded result.
  modport slave (
    input  A,
    output y,
    output v
`ifdef ONEHOT_CHECK_EN
    ,
    output onehot_err
`endif
  );

endinterface : eight_to_three_bit_enc_if

// File: rtl/eight_to_three_bit_enc_prio_enc8.sv
// Combinational 8-input priority encoder.
// MSB_PRIORITY selects whether the highest or the lowest set bit wins.
// With ONEHOT_CHECK_EN defined, also flags inputs with more than one bit set.
module prio_enc8
  import enc_pkg::*;
#(
  parameter bit MSB_PRIORITY = 1'b1
) (
  input  logic [ENC_IN_W-1:0] a,
  output enc_idx_t            idx,
  output logic                any
`ifdef ONEHOT_CHECK_EN
  ,
  output logic                multi
`endif
);

  // Scan in the direction where the winning bit is visited last, so it overwrites the rest.
  // An all-zero input leaves idx at 0.
  always_comb begin
    idx = '0;
    if (MSB_PRIORITY) begin
      for (int i = 0; i < ENC_IN_W; i++) begin
        if (a[i]) idx = enc_idx_t'(i);
      end
    end else begin
      for (int i = ENC_IN_W - 1; i >= 0; i--) begin
        if (a[i]) idx = enc_idx_t'(i);
      end
    end
  end

  assign any = |a;

`ifdef ONEHOT_CHECK_EN
  // Clearing the lowest set bit leaves something nonzero only if more than one bit was set.
  assign multi = (a & (a - ENC_IN_W'(1))) != '0;
`endif

endmodule : prio_enc8

// File: rtl/eight_to_three_bit_enc.sv
// 8-to-3 binary encoder with valid flag and registered outputs (1-cycle latency).
// Optional feature macro: ONEHOT_CHECK_EN adds the registered onehot_err output.
module eight_to_three_bit_enc
  import enc_pkg::*;
#(
  parameter bit MSB_PRIORITY = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  eight_to_three_bit_enc_if.slave  bus
);

  enc_idx_t y_d, y_q;
  logic     v_d, v_q;
`ifdef ONEHOT_CHECK_EN
  logic     err_d, err_q;
`endif

  prio_enc8 #(
    .MSB_PRIORITY (MSB_PRIORITY)
  ) u_prio_enc8 (
    .a     (bus.A),
    .idx   (y_d),
    .any   (v_d)
`ifdef ONEHOT_CHECK_EN
    ,
    .multi (err_d)
`endif
  );

  // Output register stage; reset wins over whatever A holds that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
      v_q <= 1'b0;
`ifdef ONEHOT_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      y_q <= y_d;
      v_q <= v_d;
`ifdef ONEHOT_CHECK_EN
      err_q <= err_d;
`endif
    end
  end

  assign bus.y = y_q;
  assign bus.v = v_q;
`ifdef ONEHOT_CHECK_EN
  assign bus.onehot_err = err_q;
`endif

endmodule : eight_to_three_bit_enc

// File: tb/tb_eight_to_three_bit_enc.sv
// Directed self-checking bench for eight_to_three_bit_enc.
// Build with ONEHOT_CHECK_EN defined to also exercise onehot_err.
module tb_eight_to_three_bit_enc;

  localparam bit MSB_PRIO = 1'b1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  eight_to_three_bit_enc_if bus();

  eight_to_three_bit_enc #(
    .MSB_PRIORITY (MSB_PRIO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply A away from the active edge, then advance past the next rising edge.
  task automatic tick(input logic [7:0] a);
    @(negedge clk);
    bus.A = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp_y;
    rst   = 1'b1;
    bus.A = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.y !== 3'd0) begin
        errors++;
        $display("FAIL reset_y edge%0d got %0d want 0", k, bus.y);
      end
      checks++;
      if (bus.v !== 1'b0) begin
        errors++;
        $display("FAIL reset_v edge%0d got %b want 0", k, bus.v);
      end
`ifdef ONEHOT_CHECK_EN
      checks++;
      if (bus.onehot_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_err edge%0d got %b want 0", k, bus.onehot_err);
      end
`endif
    end
    @(negedge clk);
    rst   = 1'b0;
    exp_y = MSB_PRIO ? 3'd7 : 3'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.y !== exp_y || bus.v !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got y=%0d v=%b want y=%0d v=1", bus.y, bus.v, exp_y);
    end
    $display("reset: A=FF -> y=%0d v=%b", bus.y, bus.v);
  endtask

  task automatic test_walking_one();
    logic [7:0] a;
    a = 8'h01;
    for (int i = 0; i < 8; i++) begin
      tick(a);
      checks++;
      if (bus.y !== 3'(i) || bus.v !== 1'b1) begin
        errors++;
        $display("FAIL walk A=%h got y=%0d v=%b want y=%0d v=1", a, bus.y, bus.v, i);
      end
      $display("walk: A=%h -> y=%0d v=%b", a, bus.y, bus.v);
      a = a << 1;
    end
  endtask

  task automatic test_zero_input();
    tick(8'h00);
    checks++;
    if (bus.y !== 3'd0 || bus.v !== 1'b0) begin
      errors++;
      $display("FAIL zero A=00 got y=%0d v=%b want y=0 v=0", bus.y, bus.v);
    end
    $display("zero: A=00 -> y=%0d v=%b", bus.y, bus.v);
    tick(8'h01);
    checks++;
    if (bus.y !== 3'd0 || bus.v !== 1'b1) begin
      errors++;
      $display("FAIL zero A=01 got y=%0d v=%b want y=0 v=1", bus.y, bus.v);
    end
    $display("zero: A=01 -> y=%0d v=%b", bus.y, bus.v);
  endtask

  task automatic test_priority();
    logic [7:0] vec   [3];
    logic [2:0] y_msb [3];
    logic [2:0] y_lsb [3];
    logic [2:0] exp_y;
    vec   = '{8'h81, 8'h06, 8'hFF};
    y_msb = '{3'd7, 3'd2, 3'd7};
    y_lsb = '{3'd0, 3'd1, 3'd0};
    for (int i = 0; i < 3; i++) begin
      exp_y = MSB_PRIO ? y_msb[i] : y_lsb[i];
      tick(vec[i]);
      checks++;
      if (bus.y !== exp_y || bus.v !== 1'b1) begin
        errors++;
        $display("FAIL prio A=%h got y=%0d v=%b want y=%0d v=1", vec[i], bus.y, bus.v, exp_y);
      end
      $display("prio: A=%h -> y=%0d v=%b", vec[i], bus.y, bus.v);
    end
  endtask

  task automatic test_latency();
    logic [7:0] vec   [4];
    logic [2:0] y_exp [4];
    logic       v_exp [4];
    logic [2:0] prev_y;
    logic       prev_v;
    vec    = '{8'h03, 8'h40, 8'h00, 8'h20};
    y_exp  = '{(MSB_PRIO ? 3'd1 : 3'd0), 3'd6, 3'd0, 3'd5};
    v_exp  = '{1'b1, 1'b1, 1'b0, 1'b1};
    prev_y = MSB_PRIO ? 3'd7 : 3'd0;   // from the last priority vector (FF)
    prev_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.A = vec[i];
      #1;
      checks++;
      if (bus.y !== prev_y || bus.v !== prev_v) begin
        errors++;
        $display("FAIL lat_hold A=%h got y=%0d v=%b want y=%0d v=%b", vec[i], bus.y, bus.v, prev_y, prev_v);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.y !== y_exp[i] || bus.v !== v_exp[i]) begin
        errors++;
        $display("FAIL lat_upd A=%h got y=%0d v=%b want y=%0d v=%b", vec[i], bus.y, bus.v, y_exp[i], v_exp[i]);
      end
      $display("latency: A=%h -> y=%0d v=%b", vec[i], bus.y, bus.v);
      prev_y = y_exp[i];
      prev_v = v_exp[i];
    end
  endtask

`ifdef ONEHOT_CHECK_EN
  task automatic test_onehot_check();
    tick(8'h10);
    checks++;
    if (bus.onehot_err !== 1'b0 || bus.y !== 3'd4 || bus.v !== 1'b1) begin
      errors++;
      $display("FAIL onehot A=10 got err=%b y=%0d v=%b want err=0 y=4 v=1", bus.onehot_err, bus.y, bus.v);
    end
    $display("onehot: A=10 -> err=%b y=%0d", bus.onehot_err, bus.y);
    tick(8'h18);
    checks++;
    if (bus.onehot_err !== 1'b1 || bus.y !== (MSB_PRIO ? 3'd4 : 3'd3) || bus.v !== 1'b1) begin
      errors++;
      $display("FAIL onehot A=18 got err=%b y=%0d v=%b want err=1 y=%0d v=1", bus.onehot_err, bus.y, bus.v, (MSB_PRIO ? 3'd4 : 3'd3));
    end
    $display("onehot: A=18 -> err=%b y=%0d", bus.onehot_err, bus.y);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.A  = 8'hFF;
    test_reset();
    test_walking_one();
    test_zero_input();
    test_priority();
    test_latency();
`ifdef ONEHOT_CHECK_EN
    test_onehot_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_eight_to_three_bit_enc
